// File: rtl/parking_pkg.sv
// Purpose : shared types, default parameters and helpers for the parking gate arbiter.
// Latency : n/a (package, no logic).
// Backpressure: n/a.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } arb_state_t;

    // One parking event towards parking_management, packed in port order.
    typedef struct packed {
        logic uni_exited;
        logic exited;
        logic uni_entered;
        logic entered;
    } park_evt_t;

    localparam int DEF_NUM_GATES      = 4;
    localparam int DEF_SETTLE_CYCLES  = 1;
    localparam int DEF_BARRIER_CYCLES = 8;

    // Index/counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/parking_barrier_timer.sv
// Purpose : per-gate barrier-open window timer.
// Latency : open rises in the cycle after load is sampled, stays high BARRIER_CYCLES cycles.
// Backpressure: none; a new load simply restarts the window.
//
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   load  - one-cycle pulse, (re)start the window
//   open  - level, barrier raised while the counter is non-zero
module parking_barrier_timer #(
    parameter int BARRIER_CYCLES = parking_pkg::DEF_BARRIER_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic open
);

    localparam int CNT_W = $clog2(BARRIER_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(BARRIER_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign open = (cnt != '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Purpose : round-robin arbiter sharing the parking_management event port between gates.
// Latency : request seen in IDLE cycle T -> ack/reject/event registered in cycle T+1.
// Backpressure: one accepted event per 2+SETTLE_CYCLES cycles, one reject per cycle; losers hold gate_req.
//
// Optional build macro: PARKING_ARB_UNI_PRIORITY_EN - eligible university entries win over all
// other requests (round-robin inside the uni-entry group first, then over everyone).
//
// Ports:
//   clk, reset                      - clock (rising edge), async active-high reset
//   gate_req/_is_exit/_is_uni       - per-gate level request and its qualifiers
//   uni_is_vacated_space            - uni space free (sampled only at the IDLE decision edge)
//   is_vacated_space                - general space free (sampled only at the IDLE decision edge)
//   gate_ack / gate_reject          - per-gate one-cycle response pulses
//   barrier_open                    - per-gate barrier level, BARRIER_CYCLES from the ack cycle
//   car_entered/is_uni_car_entered  - entry event pulse to parking_management
//   car_exited/is_uni_car_exited    - exit event pulse to parking_management
//   busy                            - FSM outside IDLE
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int NUM_GATES      = DEF_NUM_GATES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int BARRIER_CYCLES = DEF_BARRIER_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] gate_req,
    input  logic [NUM_GATES-1:0] gate_is_exit,
    input  logic [NUM_GATES-1:0] gate_is_uni,
    input  logic                 uni_is_vacated_space,
    input  logic                 is_vacated_space,
    output logic [NUM_GATES-1:0] gate_ack,
    output logic [NUM_GATES-1:0] gate_reject,
    output logic [NUM_GATES-1:0] barrier_open,
    output logic                 car_entered,
    output logic                 is_uni_car_entered,
    output logic                 car_exited,
    output logic                 is_uni_car_exited,
    output logic                 busy
);

    localparam int GW       = clog2_min1(NUM_GATES);
    localparam int SETTLE_W = clog2_min1(SETTLE_CYCLES + 1);

    arb_state_t           state;
    logic [GW-1:0]        rr_ptr;
    logic [SETTLE_W-1:0]  settle_cnt;
    park_evt_t            evt_q;

    logic [NUM_GATES-1:0] eligible;
    logic [NUM_GATES-1:0] cand;
    logic [NUM_GATES-1:0] sel_onehot;
    logic [NUM_GATES-1:0] barrier_load;
    logic [GW-1:0]        sel_idx;
    logic [GW-1:0]        next_ptr;
    logic                 sel_vld;
    logic                 sel_accept;
    logic                 accept;
    int                   idx;

`ifdef PARKING_ARB_UNI_PRIORITY_EN
    logic [NUM_GATES-1:0] uni_entry;
`endif

    // Selection: first candidate at or above rr_ptr, wrapping around.
    always_comb begin
        eligible = gate_req & ~barrier_open;
        cand     = eligible;
`ifdef PARKING_ARB_UNI_PRIORITY_EN
        uni_entry = eligible & gate_is_uni & ~gate_is_exit;
        if (|uni_entry) begin
            cand = uni_entry;
        end
`endif
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = 0;
        for (int i = 0; i < NUM_GATES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_GATES) begin
                idx = idx - NUM_GATES;
            end
            if (!sel_vld && cand[idx]) begin
                sel_vld = 1'b1;
                sel_idx = GW'(idx);
            end
        end

        sel_onehot          = '0;
        sel_onehot[sel_idx] = 1'b1;

        // Exits always pass; entries need a free space of their own class.
        sel_accept = gate_is_exit[sel_idx] |
                     (gate_is_uni[sel_idx] ? uni_is_vacated_space : is_vacated_space);
        accept     = (state == IDLE) && sel_vld && sel_accept;

        next_ptr = (sel_idx == GW'(NUM_GATES - 1)) ? '0 : sel_idx + 1'b1;
    end

    // The barrier counter is loaded on the decision edge so it is already
    // non-zero during the ack cycle.
    assign barrier_load = accept ? sel_onehot : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            settle_cnt  <= '0;
            evt_q       <= '0;
            gate_ack    <= '0;
            gate_reject <= '0;
        end else begin
            gate_ack    <= '0;
            gate_reject <= '0;
            evt_q       <= '0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        rr_ptr <= next_ptr;
                        if (sel_accept) begin
                            state             <= ISSUE;
                            gate_ack          <= sel_onehot;
                            evt_q.entered     <= ~gate_is_exit[sel_idx];
                            evt_q.uni_entered <= ~gate_is_exit[sel_idx] & gate_is_uni[sel_idx];
                            evt_q.exited      <= gate_is_exit[sel_idx];
                            evt_q.uni_exited  <= gate_is_exit[sel_idx] & gate_is_uni[sel_idx];
                        end else begin
                            gate_reject <= sel_onehot;
                        end
                    end
                end
                ISSUE: begin
                    if (SETTLE_CYCLES == 0) begin
                        state <= IDLE;
                    end else begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign car_entered        = evt_q.entered;
    assign is_uni_car_entered = evt_q.uni_entered;
    assign car_exited         = evt_q.exited;
    assign is_uni_car_exited  = evt_q.uni_exited;
    assign busy               = (state != IDLE);

    for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_barrier
        parking_barrier_timer #(
            .BARRIER_CYCLES(BARRIER_CYCLES)
        ) u_timer (
            .clk   (clk),
            .reset (reset),
            .load  (barrier_load[gi]),
            .open  (barrier_open[gi])
        );
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Purpose : randomized self-checking bench for parking_gate_arbiter against a timestamp model.
// Latency : model predicts outputs for the cycle after each decision edge.
// Backpressure: gates hold requests until ack/reject, with occasional withdrawal.
module tb_parking_gate_arbiter;
    import parking_pkg::*;

    localparam int NG     = 4;
    localparam int SC     = 1;
    localparam int BC     = 8;
    localparam int CYCLES = 2000;
    localparam int RST_AT = 1200;

    logic          clk = 1'b0;
    logic          reset;
    logic [NG-1:0] gate_req, gate_is_exit, gate_is_uni;
    logic          uni_is_vacated_space, is_vacated_space;
    logic [NG-1:0] gate_ack, gate_reject, barrier_open;
    logic          car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, busy;

    int total = 0;
    int bad   = 0;

    // Model state, expressed as edge timestamps rather than FSM states.
    int            edge_n;
    int            next_decide;
    int            rr;
    int            last_accept;
    int            ack_edge [NG];
    logic [NG-1:0] exp_ack, exp_rej, exp_bar;
    logic [3:0]    exp_evt;
    logic          exp_busy;

    parking_gate_arbiter #(
        .NUM_GATES      (NG),
        .SETTLE_CYCLES  (SC),
        .BARRIER_CYCLES (BC)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .gate_req             (gate_req),
        .gate_is_exit         (gate_is_exit),
        .gate_is_uni          (gate_is_uni),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .gate_ack             (gate_ack),
        .gate_reject          (gate_reject),
        .barrier_open         (barrier_open),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, 32'(gate_ack), 32'd0);
        chk({tag, "_rej"}, 32'(gate_reject), 32'd0);
        chk({tag, "_bar"}, 32'(barrier_open), 32'd0);
        chk({tag, "_evt"}, 32'({is_uni_car_exited, car_exited, is_uni_car_entered, car_entered}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic model_reset();
        rr          = 0;
        last_accept = -100;
        for (int i = 0; i < NG; i++) ack_edge[i] = -100;
    endtask

    // Called just after edge edge_n; gate_* still hold what the DUT sampled.
    task automatic model_step();
        logic [NG-1:0] elig;
        int sel;
        int g;
        exp_ack = '0;
        exp_rej = '0;
        exp_evt = '0;
        for (int i = 0; i < NG; i++) begin
            // barrier state in the cycle before this edge
            elig[i] = gate_req[i] && !((edge_n - 1 >= ack_edge[i]) && (edge_n - 1 < ack_edge[i] + BC));
        end
        sel = -1;
        if (edge_n >= next_decide) begin
`ifdef PARKING_ARB_UNI_PRIORITY_EN
            for (int i = 0; i < NG; i++) begin
                g = (rr + i) % NG;
                if (sel < 0 && elig[g] && gate_is_uni[g] && !gate_is_exit[g]) sel = g;
            end
`endif
            for (int i = 0; i < NG; i++) begin
                g = (rr + i) % NG;
                if (sel < 0 && elig[g]) sel = g;
            end
            if (sel >= 0) begin
                rr = (sel + 1) % NG;
                if (gate_is_exit[sel] || (gate_is_uni[sel] ? uni_is_vacated_space : is_vacated_space)) begin
                    exp_ack[sel]  = 1'b1;
                    ack_edge[sel] = edge_n;
                    last_accept   = edge_n;
                    next_decide   = edge_n + 2 + SC;
                    exp_evt = gate_is_exit[sel] ? {gate_is_uni[sel], 1'b1, 2'b00}
                                                : {2'b00, gate_is_uni[sel], 1'b1};
                end else begin
                    exp_rej[sel] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NG; i++) begin
            exp_bar[i] = (edge_n >= ack_edge[i]) && (edge_n < ack_edge[i] + BC);
        end
        exp_busy = (edge_n >= last_accept) && (edge_n <= last_accept + SC);
    endtask

    initial begin
        reset                = 1'b1;
        gate_req             = '0;
        gate_is_exit         = '0;
        gate_is_uni          = '0;
        uni_is_vacated_space = 1'b0;
        is_vacated_space     = 1'b0;
        edge_n               = 0;
        next_decide          = 0;
        model_reset();
        #2;
        chk_zero("rst0");
        #10;
        reset = 1'b0;

        for (int k = 0; k < CYCLES; k++) begin
            @(posedge clk);
            #1;
            model_step();
            chk("ack",  32'(gate_ack),     32'(exp_ack));
            chk("rej",  32'(gate_reject),  32'(exp_rej));
            chk("bar",  32'(barrier_open), 32'(exp_bar));
            chk("evt",  32'({is_uni_car_exited, car_exited, is_uni_car_entered, car_entered}), 32'(exp_evt));
            chk("busy", 32'(busy),         32'(exp_busy));

            if (k == RST_AT) begin
                reset = 1'b1;
                #1;
                chk_zero("rstmid");
                reset    = 1'b0;
                gate_req = '0;
                exp_ack  = '0;
                exp_rej  = '0;
                model_reset();
                next_decide = edge_n + 1;
            end

            for (int i = 0; i < NG; i++) begin
                if (gate_req[i]) begin
                    if (exp_ack[i] || exp_rej[i] || $urandom_range(0, 31) == 0) gate_req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    gate_req[i]     = 1'b1;
                    gate_is_exit[i] = ($urandom_range(0, 2) == 0);
                    gate_is_uni[i]  = ($urandom_range(0, 1) == 1);
                end
            end
            is_vacated_space     = ($urandom_range(0, 3) != 0);
            uni_is_vacated_space = ($urandom_range(0, 3) != 0);
            edge_n++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
